// File: rtl/opsel_pipe.sv
// opsel_pipe: N:1 operand selector with registered output, valid/ready
// handshake and a 2-entry skid buffer (main + skid register).
// The optional transfer counter is enabled by defining OPSEL_XFER_CNT_EN.
// Without it, xfer_cnt is tied to zero and no counter flops exist.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high on that side. accept = in_valid & in_ready and
// pop = out_valid & out_ready are evaluated on the same edge. A producer
// must hold in_data/in_sel stable while in_valid is high and in_ready is low.
// Once the block raises out_valid, out_data and out_err stay stable until
// pop occurs.
module opsel_pipe #(
  parameter int W     = 16,
  parameter int N     = 3,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N*W-1:0]   in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      xfer_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Occupancy state; checkers can bind to this signal.
  logic [1:0]   state;
  logic [W-1:0] main_data;
  logic         main_err;
  logic [W-1:0] skid_data;
  logic         skid_err;
  logic [W-1:0] sel_data;
  logic         sel_err;
  logic         accept;
  logic         pop;

  assign in_ready  = (state != FULL) & ~reset;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_err   = main_err;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Select the candidate entry; an unmatched code yields zero data with err set.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*W +: W];
        sel_err  = 1'b0;
      end
    end
  end

  // Occupancy FSM and storage; the skid entry only moves into main on a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_data <= sel_data;
            main_err  <= sel_err;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data <= sel_data;
            main_err  <= sel_err;
          end else if (accept) begin
            state     <= FULL;
            skid_data <= sel_data;
            skid_err  <= sel_err;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state     <= ONE;
            main_data <= skid_data;
            main_err  <= skid_err;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef OPSEL_XFER_CNT_EN
  logic [15:0] cnt;

  // Count every pop; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign xfer_cnt = cnt;
`else
  assign xfer_cnt = '0;
`endif

endmodule
